// File: rtl/scr1_memif_pkg.sv
// Shared memory-interface definitions for the SCR1 core-side ports.
// Provides the command, access-width and response-code enums used by the
// instruction/data memory interfaces, plus a helper that classifies an
// access as misaligned from its width and byte offset.
package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // BYTE is legal anywhere, HWORD on even offsets, WORD only on offset 0.
  // The reserved width encoding is always treated as an illegal access.
  function automatic logic scr1_mem_misaligned(input type_scr1_mem_width_e width,
                                               input logic [1:0]           off);
    logic mis;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  mis = 1'b0;
      SCR1_MEM_WIDTH_HWORD: mis = off[0];
      SCR1_MEM_WIDTH_WORD:  mis = |off;
      default:              mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/scr1_tcm_bridge_dmem_fmt.sv
// Data-port formatting for the TCM bridge (purely combinational).
// Request side : builds the byte-enable mask and lane-shifts store data
//                from the access width and byte offset.
// Response side: lane-shifts read data down by the registered offset and
//                zero-extends it to the registered access width.
// Ports:
//   req_width/req_off/req_wdata  current data request attributes
//   rsp_width/rsp_off/rsp_qb     registered attributes + raw port B data
//   be        byte enables for port B
//   wdata_sh  store data placed on its byte lanes
//   rdata_ext right-aligned, zero-extended load data
module scr1_tcm_bridge_dmem_fmt
  import scr1_memif_pkg::*;
#(
  parameter int unsigned SCR1_WIDTH = 32
) (
  input  type_scr1_mem_width_e    req_width,
  input  logic [1:0]              req_off,
  input  logic [SCR1_WIDTH-1:0]   req_wdata,
  input  type_scr1_mem_width_e    rsp_width,
  input  logic [1:0]              rsp_off,
  input  logic [SCR1_WIDTH-1:0]   rsp_qb,
  output logic [3:0]              be,
  output logic [SCR1_WIDTH-1:0]   wdata_sh,
  output logic [SCR1_WIDTH-1:0]   rdata_ext
);

  logic [3:0]            be_base;
  logic [SCR1_WIDTH-1:0] qb_sh;

  always_comb begin
    be_base = '0;
    case (req_width)
      SCR1_MEM_WIDTH_BYTE:  be_base = 4'b0001;
      SCR1_MEM_WIDTH_HWORD: be_base = 4'b0011;
      SCR1_MEM_WIDTH_WORD:  be_base = 4'b1111;
      default:              be_base = 4'b0000;
    endcase
    be       = be_base << req_off;
    wdata_sh = req_wdata << {req_off, 3'b000};
  end

  always_comb begin
    qb_sh     = rsp_qb >> {rsp_off, 3'b000};
    rdata_ext = qb_sh;
    case (rsp_width)
      SCR1_MEM_WIDTH_BYTE:  rdata_ext = {{(SCR1_WIDTH-8){1'b0}},  qb_sh[7:0]};
      SCR1_MEM_WIDTH_HWORD: rdata_ext = {{(SCR1_WIDTH-16){1'b0}}, qb_sh[15:0]};
      default:              rdata_ext = qb_sh;
    endcase
  end

endmodule

// File: rtl/scr1_tcm_bridge.sv
// Bridge between the SCR1 instruction/data memory interfaces and a
// dual-port tightly-coupled RAM (1-cycle synchronous read, byte-masked write).
// Port A serves instruction fetches (read only); port B serves data loads
// and stores. Responses appear exactly one cycle after acceptance.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req/addr/req_ack/rdata/resp fetch interface
//   dmem_req/cmd/width/addr/wdata    data request
//   dmem_req_ack/rdata/resp          data response
//   mem_rena/addra/qa                RAM port A
//   mem_renb/wenb/webb/addrb/datab/qb RAM port B
module scr1_tcm_bridge
  import scr1_memif_pkg::*;
#(
  parameter int unsigned SCR1_SIZE  = 32'h00010000,
  parameter int unsigned SCR1_WIDTH = 32,
  parameter int unsigned AW         = $clog2(SCR1_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction fetch
  input  logic                  imem_req,
  input  logic [31:0]           imem_addr,
  output logic                  imem_req_ack,
  output logic [SCR1_WIDTH-1:0] imem_rdata,
  output logic [1:0]            imem_resp,
  // data access
  input  logic                  dmem_req,
  input  logic                  dmem_cmd,
  input  logic [1:0]            dmem_width,
  input  logic [31:0]           dmem_addr,
  input  logic [SCR1_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_req_ack,
  output logic [SCR1_WIDTH-1:0] dmem_rdata,
  output logic [1:0]            dmem_resp,
  // RAM port A
  output logic                  mem_rena,
  output logic [AW-3:0]         mem_addra,
  input  logic [SCR1_WIDTH-1:0] mem_qa,
  // RAM port B
  output logic                  mem_renb,
  output logic                  mem_wenb,
  output logic [3:0]            mem_webb,
  output logic [AW-3:0]         mem_addrb,
  output logic [SCR1_WIDTH-1:0] mem_datab,
  input  logic [SCR1_WIDTH-1:0] mem_qb
);

  // Request decode
  type_scr1_mem_cmd_e   dmem_cmd_e;
  type_scr1_mem_width_e dmem_width_e;
  logic [1:0]           dmem_off;
  logic                 dmem_mis;
  logic                 dmem_wr;
  logic                 dmem_rd;
  logic                 same_word;
  logic                 imem_stall;
  logic                 imem_acc;

  // Response state
  logic                 imem_vld_q,  imem_vld_d;
  logic                 dmem_vld_q,  dmem_vld_d;
  logic                 dmem_err_q,  dmem_err_d;
  logic                 dmem_rd_q,   dmem_rd_d;
  logic [1:0]           off_reg_q,   off_reg_d;
  type_scr1_mem_width_e width_reg_q, width_reg_d;

  // Formatter outputs
  logic [3:0]            fmt_be;
  logic [SCR1_WIDTH-1:0] fmt_wdata;
  logic [SCR1_WIDTH-1:0] fmt_rdata;

  type_scr1_mem_resp_e  imem_resp_e;
  type_scr1_mem_resp_e  dmem_resp_e;

  // Address bits above the RAM size wrap; fetch byte offset is don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_addr[31:AW], imem_addr[1:0], dmem_addr[31:AW]};

  always_comb begin
    dmem_cmd_e   = type_scr1_mem_cmd_e'(dmem_cmd);
    dmem_width_e = type_scr1_mem_width_e'(dmem_width);
    dmem_off     = dmem_addr[1:0];
    dmem_mis     = scr1_mem_misaligned(dmem_width_e, dmem_off);
    dmem_wr      = dmem_req & (dmem_cmd_e == SCR1_MEM_CMD_WR) & ~dmem_mis;
    dmem_rd      = dmem_req & (dmem_cmd_e == SCR1_MEM_CMD_RD) & ~dmem_mis;
    same_word    = (imem_addr[AW-1:2] == dmem_addr[AW-1:2]);
    // Only a real store to the fetched word stalls the fetch; a load
    // (or a misaligned store, which never writes) shares the word freely.
    imem_stall   = imem_req & dmem_wr & same_word;
    imem_acc     = imem_req & ~imem_stall;
  end

  // Request-side outputs; enables are forced low while reset is asserted.
  always_comb begin
    imem_req_ack = ~imem_stall;
    dmem_req_ack = 1'b1;
    mem_rena     = imem_acc & rst_n;
    mem_addra    = imem_addr[AW-1:2];
    mem_renb     = dmem_rd & rst_n;
    mem_wenb     = dmem_wr & rst_n;
    mem_webb     = mem_wenb ? fmt_be : '0;
    mem_addrb    = dmem_addr[AW-1:2];
    mem_datab    = fmt_wdata;
  end

  always_comb begin
    imem_vld_d  = imem_acc;
    dmem_vld_d  = dmem_req;
    dmem_err_d  = dmem_req & dmem_mis;
    dmem_rd_d   = dmem_rd;
    off_reg_d   = dmem_req ? dmem_off     : off_reg_q;
    width_reg_d = dmem_req ? dmem_width_e : width_reg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_vld_q  <= 1'b0;
      dmem_vld_q  <= 1'b0;
      dmem_err_q  <= 1'b0;
      dmem_rd_q   <= 1'b0;
      off_reg_q   <= '0;
      width_reg_q <= SCR1_MEM_WIDTH_BYTE;
    end else begin
      imem_vld_q  <= imem_vld_d;
      dmem_vld_q  <= dmem_vld_d;
      dmem_err_q  <= dmem_err_d;
      dmem_rd_q   <= dmem_rd_d;
      off_reg_q   <= off_reg_d;
      width_reg_q <= width_reg_d;
    end
  end

  scr1_tcm_bridge_dmem_fmt #(
    .SCR1_WIDTH (SCR1_WIDTH)
  ) u_dmem_fmt (
    .req_width  (dmem_width_e),
    .req_off    (dmem_off),
    .req_wdata  (dmem_wdata),
    .rsp_width  (width_reg_q),
    .rsp_off    (off_reg_q),
    .rsp_qb     (mem_qb),
    .be         (fmt_be),
    .wdata_sh   (fmt_wdata),
    .rdata_ext  (fmt_rdata)
  );

  // Response-side outputs: data is gated so nothing leaks outside the
  // response cycle (RAM outputs hold stale values between reads).
  always_comb begin
    imem_resp_e = imem_vld_q ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
    imem_rdata  = imem_vld_q ? mem_qa : '0;

    dmem_resp_e = SCR1_MEM_RESP_NOTRDY;
    if (dmem_vld_q) begin
      dmem_resp_e = dmem_err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    end
    dmem_rdata  = (dmem_vld_q & dmem_rd_q) ? fmt_rdata : '0;

    imem_resp   = imem_resp_e;
    dmem_resp   = dmem_resp_e;
  end

endmodule
